// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative MULT/MULTU/DIV/DIVU unit for EX, results in HI/LO.
// Ports: clk, reset, start, op, a, b, abort in; busy, done, div_zero, hi, lo out.
module ex_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int W2 = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] ma_q, ma_d;
  logic [WIDTH-1:0] mb_q, mb_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic             qsign_q, qsign_d;
  logic             rsign_q, rsign_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;

  logic             signed_op;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH:0]   msum;
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;
  logic [W2-1:0]    prod;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rmd;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    a_d     = a_q;
    qsign_d = qsign_q;
    rsign_d = rsign_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dz_d    = dz_q;

    signed_op = ~op[0];
    a_neg     = signed_op & a[WIDTH-1];
    b_neg     = signed_op & b[WIDTH-1];

    // multiply: add multiplicand into upper half, shift right
    msum = {1'b0, acc_q[W2-1:WIDTH]}
         + (acc_q[0] ? {1'b0, ma_q} : '0);

    // divide: low half of acc holds dividend/quotient
    shifted = {rem_q, acc_q[WIDTH-1]};
    trial   = shifted - {2'b0, mb_q};

    prod = qsign_q ? -acc_q : acc_q;
    quo  = qsign_q ? -acc_q[WIDTH-1:0]
                   : acc_q[WIDTH-1:0];
    rmd  = rsign_q ? -rem_q[WIDTH-1:0]
                   : rem_q[WIDTH-1:0];

    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          op_d    = op;
          ma_d    = a_neg ? -a : a;
          mb_d    = b_neg ? -b : b;
          a_d     = a;
          qsign_d = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
          rsign_d = a_neg;
          cnt_d   = '0;
          rem_d   = '0;
          acc_d   = op[1] ? {{WIDTH{1'b0}}, ma_d}
                          : {{WIDTH{1'b0}}, mb_d};
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (op_q[1]) begin
            if (trial[WIDTH+1]) begin
              rem_d = shifted[WIDTH:0];
              acc_d = {acc_q[W2-1:WIDTH],
                       acc_q[WIDTH-2:0], 1'b0};
            end else begin
              rem_d = trial[WIDTH:0];
              acc_d = {acc_q[W2-1:WIDTH],
                       acc_q[WIDTH-2:0], 1'b1};
            end
          end else begin
            acc_d = {msum, acc_q[WIDTH-1:1]};
          end
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = S_FIX;
          end
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!abort) begin
          done_d = 1'b1;
          if (op_q[1]) begin
            if (mb_q == '0) begin
              hi_d = a_q;
              lo_d = '1;
              dz_d = 1'b1;
            end else begin
              hi_d = rmd;
              lo_d = quo;
              dz_d = 1'b0;
            end
          end else begin
            hi_d = prod[W2-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
            dz_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      ma_q    <= '0;
      mb_q    <= '0;
      a_q     <= '0;
      qsign_q <= 1'b0;
      rsign_q <= 1'b0;
      acc_q   <= '0;
      rem_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      a_q     <= a_d;
      qsign_q <= qsign_d;
      rsign_q <= rsign_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed scoreboard bench for ex_muldiv.
// Expected HI/LO/div_zero come from a 64-bit arithmetic model.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        abort = 1'b0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  int          first_cyc = 0;
  logic [31:0] prev_hi = '0;
  logic [31:0] prev_lo = '0;
  logic [64:0] sb_q[$];

  ex_muldiv #(.WIDTH(32)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .op(op),
    .a(a),
    .b(b),
    .abort(abort),
    .busy(busy),
    .done(done),
    .div_zero(div_zero),
    .hi(hi),
    .lo(lo)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [64:0] model(
    input logic [1:0] o,
    input logic [31:0] x,
    input logic [31:0] y);
    logic signed [63:0] sx, sy, sq, sr;
    logic [63:0] ux, uy, p, uq, ur;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    ux = {32'b0, x};
    uy = {32'b0, y};
    if (o == 2'b00) begin
      p = sx * sy;
      return {1'b0, p};
    end
    if (o == 2'b01) begin
      p = ux * uy;
      return {1'b0, p};
    end
    if (y == 32'd0)
      return {1'b1, x, 32'hFFFF_FFFF};
    if (o == 2'b10) begin
      sq = sx / sy;
      sr = sx % sy;
      return {1'b0, sr[31:0], sq[31:0]};
    end
    uq = ux / uy;
    ur = ux % uy;
    return {1'b0, ur[31:0], uq[31:0]};
  endfunction

  task automatic issue(input logic [1:0] o,
                       input logic [31:0] x,
                       input logic [31:0] y,
                       input bit push);
    op = o;
    a = x;
    b = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    start_cyc = cyc;
    if (push) sb_q.push_back(model(o, x, y));
  endtask

  task automatic wait_done(input string tag);
    int n;
    bit busy_ok;
    bit stable;
    logic [64:0] e;
    n = 0;
    busy_ok = 1'b1;
    stable = 1'b1;
    while (!done && n < 40) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (hi !== prev_hi || lo !== prev_lo) stable = 1'b0;
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_lat"}, 64'(cyc - start_cyc), 64'd33);
    chk({tag, "_busyrun"}, 64'(busy_ok), 64'd1);
    chk({tag, "_stable"}, 64'(stable), 64'd1);
    chk({tag, "_busy0"}, 64'(busy), 64'd0);
    chk({tag, "_sb"}, 64'(sb_q.size() > 0), 64'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({tag, "_hi"}, 64'(hi), 64'(e[63:32]));
      chk({tag, "_lo"}, 64'(lo), 64'(e[31:0]));
      chk({tag, "_dz"}, 64'(div_zero), 64'(e[64]));
      prev_hi = e[63:32];
      prev_lo = e[31:0];
    end
  endtask

  initial begin
    bit no_done;

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dz", 64'(div_zero), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);

    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_done("multu_max");
    chk("multu_max_done", 64'(done), 64'd1);
    @(posedge clk);
    #1;
    chk("multu_max_pulse", 64'(done), 64'd0);

    issue(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b1);
    wait_done("mult_neg");
    issue(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_done("div_neg");
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_done("div_ovf");
    issue(2'b00, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 1'b1);
    wait_done("mult_nn");
    issue(2'b10, 32'd7, 32'hFFFF_FFFE, 1'b1);
    wait_done("div_pn");

    issue(2'b11, 32'd100, 32'd0, 1'b1);
    wait_done("divu_zero");
    issue(2'b11, 32'd100, 32'd7, 1'b1);
    wait_done("divu_100_7");

    // second start while busy must be dropped
    issue(2'b01, 32'd5, 32'd6, 1'b1);
    first_cyc = start_cyc;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    op = 2'b11;
    a = 32'd9;
    b = 32'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("ign_start");
    issue(2'b11, 32'd9, 32'd3, 1'b1);
    wait_done("b2b");
    chk("b2b_total", 64'(cyc - first_cyc), 64'd67);

    issue(2'b11, 32'h451, 32'h20, 1'b1);
    wait_done("preset");

    issue(2'b11, 32'd50, 32'd5, 1'b0);
    repeat (8) begin
      @(posedge clk);
      #1;
    end
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_hi", 64'(hi), 64'h11);
    chk("abort_lo", 64'(lo), 64'h22);
    chk("abort_dz", 64'(div_zero), 64'd0);
    no_done = 1'b1;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0) no_done = 1'b0;
    end
    chk("abort_nodone", 64'(no_done), 64'd1);

    issue(2'b10, 32'd5, 32'd0, 1'b1);
    wait_done("div_zero2");

    issue(2'b00, 32'd123, 32'd456, 1'b0);
    repeat (18) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_done", 64'(done), 64'd0);
    chk("mrst_dz", 64'(div_zero), 64'd0);
    chk("mrst_hi", 64'(hi), 64'd0);
    chk("mrst_lo", 64'(lo), 64'd0);
    prev_hi = '0;
    prev_lo = '0;

    issue(2'b01, 32'h0001_0000, 32'h0001_0000, 1'b1);
    wait_done("post_rst");

    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative multiply/divide unit in the EX stage of the pipelined MIPS datapath. It reads the register operands that the ID/EX pipeline register presents and computes MULT, MULTU, DIV and DIVU results into architectural HI/LO registers over multiple cycles. While it works, it holds `busy` high so the hazard logic can stall ID and IF and insert bubbles.

## Interface

Parameters:

- `WIDTH`, default 32: operand width. HI and LO are each `WIDTH` bits. The iteration count equals `WIDTH`.

Ports:

- `clk`, input, 1: single clock. All state updates on `posedge clk`.
- `reset`, input, 1: synchronous, active-high. Clears all state.
- `start`, input, 1: launch request, decoded from the ID/EX control word. Sampled only in IDLE.
- `op`, input, 2: operation select. 00 = MULT, 01 = MULTU, 10 = DIV, 11 = DIVU.
- `a`, input, WIDTH: rs operand (ID/EX readData1). Multiplicand or dividend.
- `b`, input, WIDTH: rt operand (ID/EX readData2). Multiplier or divisor.
- `abort`, input, 1: pipeline flush. Cancels an in-flight operation.
- `busy`, output, 1: operation in flight. Drives the stall request.
- `done`, output, 1: one-cycle pulse when HI/LO are updated.
- `div_zero`, output, 1: set together with `done` when a DIV/DIVU divisor is 0. Held until the next `done`.
- `hi`, output, WIDTH: HI register.
- `lo`, output, WIDTH: LO register.

## Operation

- FSM states: IDLE, RUN, FIX.
- IDLE:
  - If `start` is high and `abort` is low, latch `op`, and latch |a| and |b| (absolute values for signed ops, raw values for unsigned ops).
  - Record the result signs:
    - quotient/product sign = a[MSB] xor b[MSB] (signed ops only);
    - remainder sign = a[MSB].
  - Clear the iteration counter and the partial accumulators, then go to RUN.
- RUN: one iteration per cycle. After iteration WIDTH-1, go to FIX. Counter is `$clog2(WIDTH)+1` bits.
  - Multiply: shift-add over a 2*WIDTH accumulator. Examine one multiplier bit per cycle, LSB first.
  - Divide: restoring division, one quotient bit per cycle, MSB first. Remainder register is WIDTH+1 bits to hold the trial-subtract borrow.
- FIX: apply the sign fixup in two's complement, then write `hi`/`lo`, pulse `done`, and return to IDLE.
  - Multiply results: hi = product[2W-1:W], lo = product[W-1:0]. Negate the 2W product if its sign flag is set.
  - Divide results: lo = quotient, hi = remainder. Negate the quotient and the remainder independently per their sign flags.
- Division by zero:
  - FIX skips the sign fixup and writes hi = original `a`, lo = all-ones, `div_zero` = 1.
  - Latency is unchanged.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF yields lo = 0x80000000, hi = 0. This falls out of the unsigned magnitude path and needs no special case.
- `start` in RUN or FIX is ignored; no queueing.
- `abort` in RUN or FIX:
  - next state is IDLE;
  - `hi`, `lo` and `div_zero` are unchanged;
  - no `done` pulse.
- `abort` has priority over `start` in IDLE.
- `reset` has priority over everything: next state IDLE, counter 0, `hi` = `lo` = 0, `busy` = `done` = `div_zero` = 0.

## Timing

- Reset values: `busy` 0, `done` 0, `div_zero` 0, `hi` 0, `lo` 0.
- `start` sampled at posedge N:
  - `busy` = 1 after posedges N through N+32 (33 cycles);
  - iterations occur on posedges N+1 through N+32;
  - FIX executes on posedge N+33;
  - after posedge N+33: `busy` = 0, `done` = 1 for exactly one cycle, and `hi`/`lo` hold the new values.
- Latency from start to result is WIDTH+1 posedges. It does not depend on operand values or on `op`.
- `busy` is a registered output, so the stall request appears the cycle after acceptance. The hazard logic covers that first cycle by decoding `start` combinationally.
- A `start` that is high in the same cycle as `done` is accepted, because the FSM is already in IDLE. Back-to-back operations are therefore spaced 34 cycles apart.
- `hi`/`lo` change only on FIX or reset. They are stable throughout RUN, so readers see the previous result.
- `done` is a registered pulse. It is 0 on any cycle that follows an abort or a reset.

## Test plan

- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF, start at N -> at N+33: done=1, hi=0xFFFFFFFE, lo=0x00000001, busy=0; done=0 at N+34.
- MULT a=-3, b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=0x80000000, b=-1 -> lo=0x80000000, hi=0.
- DIVU a=100, b=0 -> hi=100, lo=0xFFFFFFFF, div_zero=1 at N+33. A following DIVU 100/7 -> lo=14, hi=2, div_zero=0.
- Start MULTU 5*6, then assert start with DIVU 9/3 at N+5 -> second request ignored; hi=0, lo=30 at N+33. Restart at N+33 (done cycle) -> accepted; lo=3, hi=0 at N+67.
- Start DIVU 50/5 with prior hi/lo = 0x11/0x22, abort at N+10 -> busy=0 after N+10, no done, hi/lo stay 0x11/0x22. Reset asserted at N+20 of a new operation -> next cycle all outputs are 0 and state is IDLE.
